bsg_fifo_to_io_store_sync: RTL and testbench

//  Downstream consumer of the AXI-lite write FIFO (v/addr/data/yumi). Merges 32-bit host writes

---
 rtl/bsg_fifo_to_io_store_sync_if.sv | 39 +++
 rtl/bsg_fifo_to_io_store_sync.sv | 138 +++++++++++++
 tb/tb_bsg_fifo_to_io_store_sync.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_fifo_to_io_store_sync_if.sv
// Handshake bundle between the AXI-lite write FIFO, the store merger
// and the BP I/O command/response network.
interface bsg_fifo_to_io_store_sync_if #(
    parameter int addr_width_p  = 32,
    parameter int paddr_width_p = 40
);
    logic                     v_i;
    logic [addr_width_p-1:0]  addr_i;
    logic [31:0]              data_i;
    logic                     yumi_o;

    logic                     io_cmd_v_o;
    logic [paddr_width_p-1:0] io_cmd_addr_o;
    logic [1:0]               io_cmd_size_o;
    logic [63:0]              io_cmd_data_o;
    logic                     io_cmd_ready_and_i;

    logic                     io_resp_v_i;
    logic                     io_resp_yumi_o;
    logic                     credits_empty_o;

    modport slave (
        input  v_i, addr_i, data_i,
        input  io_cmd_ready_and_i, io_resp_v_i,
        output yumi_o,
        output io_cmd_v_o, io_cmd_addr_o,
        output io_cmd_size_o, io_cmd_data_o,
        output io_resp_yumi_o, credits_empty_o
    );

    modport master (
        output v_i, addr_i, data_i,
        output io_cmd_ready_and_i, io_resp_v_i,
        input  yumi_o,
        input  io_cmd_v_o, io_cmd_addr_o,
        input  io_cmd_size_o, io_cmd_data_o,
        input  io_resp_yumi_o, credits_empty_o
    );
endinterface

// File: rtl/bsg_fifo_to_io_store_sync.sv
// Merges low/high 32-bit FIFO writes of one dword into 64-bit I/O stores,
// flushes unpaired words as 32-bit stores, and caps outstanding stores.
module bsg_fifo_to_io_store_sync #(
    parameter int                      addr_width_p      = 32,
    parameter int                      paddr_width_p     = 40,
    parameter logic [paddr_width_p-1:0] base_addr_p      = '0,
    parameter int                      max_outstanding_p = 4,
    parameter int                      flush_cycles_p    = 64
) (
    input logic                         clk_i,
    input logic                         reset_i,
    bsg_fifo_to_io_store_sync_if.slave  bus
);
    localparam int cnt_w = $clog2(max_outstanding_p + 1);
    localparam int tmr_w = (flush_cycles_p > 1) ? $clog2(flush_cycles_p) : 1;
    localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(max_outstanding_p);
    localparam logic [tmr_w-1:0] tmr_last = tmr_w'(flush_cycles_p - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SEND = 2'd2
    } state_e;

    state_e state_r, state_n;

    logic [addr_width_p-1:0]  held_addr_r;
    logic [31:0]              held_data_r;
    logic [tmr_w-1:0]         timer_r;
    logic [cnt_w-1:0]         outstanding_r;
    logic [paddr_width_p-1:0] cmd_addr_r;
    logic [1:0]               cmd_size_r;
    logic [63:0]              cmd_data_r;

    logic hi_word, same_dword, pair, timeout, hs;

    assign hi_word    = bus.addr_i[2];
    assign same_dword = bus.addr_i[addr_width_p-1:3] == held_addr_r[addr_width_p-1:3];
    assign pair       = bus.v_i & hi_word & same_dword;
    assign timeout    = timer_r == tmr_last;
    assign hs         = bus.io_cmd_v_o & bus.io_cmd_ready_and_i;

    function automatic logic [paddr_width_p-1:0] store_addr(
        input logic [addr_width_p-1:0] a,
        input logic                    dword
    );
        logic [paddr_width_p-1:0] ext;
        ext      = paddr_width_p'(a);
        ext[1:0] = 2'b00;
        if (dword) ext[2] = 1'b0;
        return base_addr_p + ext;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE:    if (bus.v_i) state_n = hi_word ? SEND : HOLD;
            HOLD:    if (bus.v_i || timeout) state_n = SEND;
            SEND:    if (hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.yumi_o     = 1'b0;
        bus.io_cmd_v_o = 1'b0;
        unique case (state_r)
            IDLE:    bus.yumi_o     = bus.v_i;
            HOLD:    bus.yumi_o     = pair;
            SEND:    bus.io_cmd_v_o = outstanding_r < cnt_max;
            default: ;
        endcase
    end

    // Command register only loads outside SEND, so fields hold while offered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            held_addr_r   <= '0;
            held_data_r   <= '0;
            timer_r       <= '0;
            outstanding_r <= '0;
            cmd_addr_r    <= '0;
            cmd_size_r    <= 2'b10;
            cmd_data_r    <= '0;
        end else begin
            if (hs && !bus.io_resp_v_i)
                outstanding_r <= outstanding_r + cnt_w'(1);
            else if (!hs && bus.io_resp_v_i)
                outstanding_r <= outstanding_r - cnt_w'(1);

            unique case (state_r)
                IDLE: begin
                    if (bus.v_i) begin
                        timer_r <= '0;
                        if (hi_word) begin
                            cmd_addr_r <= store_addr(bus.addr_i, 1'b0);
                            cmd_size_r <= 2'b10;
                            cmd_data_r <= {bus.data_i, bus.data_i};
                        end else begin
                            held_addr_r <= bus.addr_i;
                            held_data_r <= bus.data_i;
                        end
                    end
                end
                HOLD: begin
                    if (pair) begin
                        cmd_addr_r <= store_addr(held_addr_r, 1'b1);
                        cmd_size_r <= 2'b11;
                        cmd_data_r <= {bus.data_i, held_data_r};
                    end else if (bus.v_i || timeout) begin
                        cmd_addr_r <= store_addr(held_addr_r, 1'b0);
                        cmd_size_r <= 2'b10;
                        cmd_data_r <= {held_data_r, held_data_r};
                    end else begin
                        timer_r <= timer_r + tmr_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.io_cmd_addr_o   = cmd_addr_r;
    assign bus.io_cmd_size_o   = cmd_size_r;
    assign bus.io_cmd_data_o   = cmd_data_r;
    assign bus.io_resp_yumi_o  = bus.io_resp_v_i;
    assign bus.credits_empty_o = outstanding_r == '0;

    // A response with nothing in flight means the network is broken.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.io_resp_v_i && outstanding_r == '0));

endmodule

// File: tb/tb_bsg_fifo_to_io_store_sync.sv
// Bench for the FIFO-to-I/O store merger: directed vector table,
// hand-written corner sequences and randomized traffic vs a pairing model.
module tb_bsg_fifo_to_io_store_sync;
    localparam int AW   = 32;
    localparam int PW   = 40;
    localparam int MAXO = 4;
    localparam int FLSH = 64;
    localparam logic [PW-1:0] BASE = 40'hFF_FFFF_F000;
    localparam logic [PW-1:0] M4   = ~40'h3;
    localparam logic [PW-1:0] M8   = ~40'h7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bsg_fifo_to_io_store_sync_if #(.addr_width_p(AW), .paddr_width_p(PW)) bus();

    bsg_fifo_to_io_store_sync #(
        .addr_width_p(AW), .paddr_width_p(PW), .base_addr_p(BASE),
        .max_outstanding_p(MAXO), .flush_cycles_p(FLSH)
    ) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // v, addr, data, rdy, resp | yumi, cmd_v, size, cmd data, addr offset, empty
    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        resp;
        logic        yumi;
        logic        cmd_v;
        logic [1:0]  size;
        logic [63:0] cdata;
        logic [31:0] coff;
        logic        empty;
    } vec_t;
    vec_t tbl [11];

    typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
    typedef struct { logic [PW-1:0] a; logic [1:0] s; logic [63:0] d; } cmd_t;

    ent_t drvq [$];
    cmd_t expq [$];
    bit   m_held;
    ent_t m_h;
    int   out;
    int   hs_cnt;
    logic last_cmd_v;
    bit   gaps;

    function automatic cmd_t cmd4(input ent_t e);
        cmd_t c;
        c.a = BASE + (PW'(e.a) & M4);
        c.s = 2'b10;
        c.d = {e.d, e.d};
        return c;
    endfunction

    // Reference: walk writes in order; a low word waits for its high partner.
    task automatic model_put(input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        cmd_t c;
        e.a = a;
        e.d = d;
        drvq.push_back(e);
        if (m_held) begin
            m_held = 0;
            if (a[2] && a[31:3] == m_h.a[31:3]) begin
                c.a = BASE + (PW'(a) & M8);
                c.s = 2'b11;
                c.d = {d, m_h.d};
                expq.push_back(c);
                return;
            end
            expq.push_back(cmd4(m_h));
        end
        if (a[2]) expq.push_back(cmd4(e));
        else begin
            m_held = 1;
            m_h    = e;
        end
    endtask

    task automatic model_flush();
        if (m_held) expq.push_back(cmd4(m_h));
        m_held = 0;
    endtask

    task automatic step(input bit rdy, input bit resp);
        bit   r;
        cmd_t c;
        @(negedge clk);
        r = resp && out > 0;
        bus.v_i = drvq.size() > 0 && !(gaps && $urandom_range(0, 3) == 0);
        if (drvq.size() > 0) begin
            bus.addr_i = drvq[0].a;
            bus.data_i = drvq[0].d;
        end
        bus.io_cmd_ready_and_i = rdy;
        bus.io_resp_v_i        = r;
        #1;
        last_cmd_v = bus.io_cmd_v_o;
        chk("credits_empty", bus.credits_empty_o, out == 0);
        chk("resp_yumi", bus.io_resp_yumi_o, r);
        chk("credit_limit", bus.io_cmd_v_o && out >= MAXO, 0);
        if (bus.yumi_o) begin
            chk("yumi_needs_v", bus.v_i, 1);
            if (bus.v_i) void'(drvq.pop_front());
        end
        if (bus.io_cmd_v_o && rdy) begin
            hs_cnt++;
            out++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got addr %0h size %0h data %0h expected none",
                         bus.io_cmd_addr_o, bus.io_cmd_size_o, bus.io_cmd_data_o);
            end else begin
                c = expq.pop_front();
                chk("sb_addr", bus.io_cmd_addr_o, c.a);
                chk("sb_size", bus.io_cmd_size_o, c.s);
                chk("sb_data", bus.io_cmd_data_o, c.d);
            end
        end
        if (r) out--;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((drvq.size() > 0 || expq.size() > 0 || out > 0) && n < bound) begin
            step(1'b1, $urandom_range(0, 1) == 1);
            n++;
        end
        chk("drain_in_bound", n < bound, 1);
    endtask

    task automatic put_pair(input logic [31:0] a);
        model_put(a, $urandom());
        model_put(a | 32'h4, $urandom());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int early, moved, h0, fired;
        logic [63:0] d0;

        reset = 1'b1;
        bus.v_i = 0; bus.addr_i = '0; bus.data_i = '0;
        bus.io_cmd_ready_and_i = 0; bus.io_resp_v_i = 0;
        out = 0; hs_cnt = 0; m_held = 0; gaps = 0; last_cmd_v = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        tbl[0]  = '{0, 32'h0,  32'h0,        0, 0, 0, 0, 2'b00, 64'h0, 32'h0, 1};
        tbl[1]  = '{1, 32'h0,  32'hAAAA0000, 0, 0, 1, 0, 2'b00, 64'h0, 32'h0, 1};
        tbl[2]  = '{1, 32'h4,  32'hBBBB1111, 0, 0, 1, 0, 2'b00, 64'h0, 32'h0, 1};
        tbl[3]  = '{0, 32'h0,  32'h0,        1, 0, 0, 1, 2'b11,
                    64'hBBBB1111_AAAA0000, 32'h0, 1};
        tbl[4]  = '{1, 32'h4,  32'h12345678, 0, 0, 1, 0, 2'b00, 64'h0, 32'h0, 0};
        tbl[5]  = '{0, 32'h0,  32'h0,        0, 0, 0, 1, 2'b10,
                    64'h12345678_12345678, 32'h4, 0};
        tbl[6]  = '{0, 32'h0,  32'h0,        1, 1, 0, 1, 2'b10,
                    64'h12345678_12345678, 32'h4, 0};
        tbl[7]  = '{1, 32'h8,  32'h1,        0, 1, 1, 0, 2'b00, 64'h0, 32'h0, 0};
        tbl[8]  = '{1, 32'h10, 32'h2,        0, 0, 0, 0, 2'b00, 64'h0, 32'h0, 1};
        tbl[9]  = '{1, 32'h10, 32'h2,        1, 0, 0, 1, 2'b10,
                    64'h00000001_00000001, 32'h8, 1};
        tbl[10] = '{1, 32'h10, 32'h2,        0, 0, 1, 0, 2'b00, 64'h0, 32'h0, 0};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.v_i = tbl[i].v;
            bus.addr_i = tbl[i].addr;
            bus.data_i = tbl[i].data;
            bus.io_cmd_ready_and_i = tbl[i].rdy;
            bus.io_resp_v_i = tbl[i].resp;
            #1;
            chk($sformatf("vec%0d_yumi", i), bus.yumi_o, tbl[i].yumi);
            chk($sformatf("vec%0d_cmd_v", i), bus.io_cmd_v_o, tbl[i].cmd_v);
            chk($sformatf("vec%0d_empty", i), bus.credits_empty_o, tbl[i].empty);
            if (tbl[i].cmd_v) begin
                chk($sformatf("vec%0d_addr", i), bus.io_cmd_addr_o, BASE + PW'(tbl[i].coff));
                chk($sformatf("vec%0d_size", i), bus.io_cmd_size_o, tbl[i].size);
                chk($sformatf("vec%0d_data", i), bus.io_cmd_data_o, tbl[i].cdata);
            end
        end

        // Held 0x10 must wait exactly FLSH idle cycles before flushing.
        early = 0;
        for (int i = 0; i < FLSH; i++) begin
            @(negedge clk);
            bus.v_i = 0; bus.io_cmd_ready_and_i = 0; bus.io_resp_v_i = 0;
            #1;
            if (bus.io_cmd_v_o) early++;
        end
        chk("flush_early", early, 0);
        @(negedge clk);
        #1;
        chk("flush_cmd_v", bus.io_cmd_v_o, 1);
        chk("flush_addr", bus.io_cmd_addr_o, BASE + 40'h10);
        chk("flush_size", bus.io_cmd_size_o, 2'b10);
        chk("flush_data", bus.io_cmd_data_o, 64'h00000002_00000002);

        // Stalled command stays put and the FIFO is not consumed.
        d0 = bus.io_cmd_data_o;
        moved = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.v_i = 1; bus.addr_i = 32'h20; bus.data_i = 32'h33;
            bus.io_cmd_ready_and_i = 0;
            #1;
            chk($sformatf("stall%0d_yumi", i), bus.yumi_o, 0);
            if (!bus.io_cmd_v_o || bus.io_cmd_data_o !== d0 ||
                bus.io_cmd_addr_o !== BASE + 40'h10) moved++;
        end
        chk("stall_stable", moved, 0);
        @(negedge clk);
        bus.io_cmd_ready_and_i = 1;
        #1;
        chk("stall_release_v", bus.io_cmd_v_o, 1);
        @(negedge clk);
        bus.io_cmd_ready_and_i = 0;
        #1;
        chk("low_0x20_yumi", bus.yumi_o, 1);
        chk("two_outstanding", bus.credits_empty_o, 0);

        // Reset while a low word is held: nothing may be issued afterwards.
        @(negedge clk);
        bus.v_i = 0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_empty", bus.credits_empty_o, 1);
        chk("rst_cmd_v", bus.io_cmd_v_o, 0);
        chk("rst_yumi", bus.yumi_o, 0);
        fired = 0;
        for (int i = 0; i < FLSH + 6; i++) begin
            @(negedge clk);
            bus.io_cmd_ready_and_i = 1;
            #1;
            if (bus.io_cmd_v_o) fired++;
        end
        chk("rst_no_store", fired, 0);

        // Credit cap: five pairs, no responses.
        for (int k = 0; k < 5; k++) put_pair(32'h1000 + 32'(k * 8));
        h0 = hs_cnt;
        repeat (30) step(1'b1, 1'b0);
        chk("cap_issued", hs_cnt - h0, 4);
        chk("cap_blocked", last_cmd_v, 0);
        step(1'b1, 1'b1);
        chk("cap_blocked_on_resp", last_cmd_v, 0);
        h0 = hs_cnt;
        step(1'b1, 1'b1);
        chk("issue_with_resp", hs_cnt - h0, 1);
        put_pair(32'h2000);
        h0 = hs_cnt;
        repeat (6) step(1'b1, 1'b0);
        chk("issue_to_cap", hs_cnt - h0, 1);
        put_pair(32'h2008);
        h0 = hs_cnt;
        repeat (6) step(1'b1, 1'b0);
        chk("cap_again", hs_cnt - h0, 0);
        chk("cap_again_v", last_cmd_v, 0);
        model_flush();
        drain(300);

        // Randomized traffic against the pairing model.
        gaps = 1;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] dw;
            int kind;
            dw = ($urandom_range(0, 7) == 0) ? ($urandom() & ~32'h7)
                                             : (32'($urandom_range(0, 7)) << 3);
            kind = $urandom_range(0, 3);
            if (kind < 2)       put_pair(dw);
            else if (kind == 2) model_put(dw, $urandom());
            else                model_put(dw | 32'h4, $urandom());
        end
        begin
            int n = 0;
            while (drvq.size() > 0 && n < 5000) begin
                step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
                n++;
            end
            chk("random_consumed", n < 5000, 1);
        end
        gaps = 0;
        model_flush();
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
